// File: rtl/bip_core_ctrl.sv
// ============================================================================
// bip_core_ctrl : multi-cycle BIP core with start/halt, single-step, illegal
//                 opcode flag and saturating busy-cycle counter.
// Revision 1.0
// ============================================================================
`default_nettype none

module bip_core_ctrl #(
   parameter int NBITS_D  = 16,
   parameter int NBITS_O  = 11,
   parameter int OPCODE   = 5,
   parameter int PM_DEPTH = 2048,
   parameter int CNT_W    = 32
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_start,
   input  logic               i_step_mode,
   input  logic               i_step,
   output logic [NBITS_O-1:0] o_pm_addr,
   input  logic [NBITS_D-1:0] i_pm_data,
   output logic [NBITS_O-1:0] o_dm_addr,
   output logic               o_dm_rd,
   output logic               o_dm_wr,
   output logic [NBITS_D-1:0] o_dm_wdata,
   input  logic [NBITS_D-1:0] i_dm_rdata,
   output logic [NBITS_D-1:0] o_acc,
   output logic               o_busy,
   output logic               o_halted,
   output logic               o_illegal,
   output logic [CNT_W-1:0]   o_cycles
);

   localparam logic [OPCODE-1:0] OP_HLT  = OPCODE'(0);
   localparam logic [OPCODE-1:0] OP_STO  = OPCODE'(1);
   localparam logic [OPCODE-1:0] OP_LD   = OPCODE'(2);
   localparam logic [OPCODE-1:0] OP_LDI  = OPCODE'(3);
   localparam logic [OPCODE-1:0] OP_ADD  = OPCODE'(4);
   localparam logic [OPCODE-1:0] OP_ADDI = OPCODE'(5);
   localparam logic [OPCODE-1:0] OP_SUB  = OPCODE'(6);
   localparam logic [OPCODE-1:0] OP_SUBI = OPCODE'(7);
   localparam logic [NBITS_O-1:0] PC_LAST = NBITS_O'(PM_DEPTH - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      PAUSE  = 3'd5,
      HALT   = 3'd6
   } state_t;

   state_t             state;
   state_t             next_st;
   logic [NBITS_O-1:0] pc;
   logic [NBITS_O-1:0] pc_inc;
   logic [NBITS_D-1:0] ir;
   logic [NBITS_D-1:0] acc;
   logic [NBITS_D-1:0] imm;
   logic [OPCODE-1:0]  op;
   logic [OPCODE-1:0]  fetch_op;
   logic [NBITS_O-1:0] operand;
   logic [CNT_W-1:0]   cycles;
   logic               illegal;
   logic               dm_rd;
   logic               dm_wr;
   logic               busy;

   assign op       = ir[NBITS_D-1:NBITS_O];
   assign operand  = ir[NBITS_O-1:0];
   assign fetch_op = i_pm_data[NBITS_D-1:NBITS_O];
   assign imm      = {{(NBITS_D-NBITS_O){operand[NBITS_O-1]}}, operand};
   assign pc_inc   = (pc == PC_LAST) ? '0 : pc + NBITS_O'(1);
   assign next_st  = i_step_mode ? PAUSE : FETCH;
   assign busy     = (state == FETCH) || (state == DECODE) ||
                     (state == EXEC)  || (state == MEM);

   assign o_pm_addr  = pc;
   assign o_dm_addr  = operand;
   assign o_dm_rd    = dm_rd;
   assign o_dm_wr    = dm_wr;
   assign o_dm_wdata = acc;
   assign o_acc      = acc;
   assign o_busy     = busy;
   assign o_halted   = (state == HALT);
   assign o_illegal  = illegal;
   assign o_cycles   = cycles;

   // Strobes are registered from the word arriving in DECODE so they are
   // high for exactly the EXEC cycle.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state   <= IDLE;
         pc      <= '0;
         ir      <= '0;
         acc     <= '0;
         cycles  <= '0;
         illegal <= 1'b0;
         dm_rd   <= 1'b0;
         dm_wr   <= 1'b0;
      end else begin
         dm_rd <= 1'b0;
         dm_wr <= 1'b0;
         if (busy && (cycles != '1))
            cycles <= cycles + CNT_W'(1);
         case (state)
            IDLE, HALT: begin
               if (i_start) begin
                  pc      <= '0;
                  acc     <= '0;
                  cycles  <= '0;
                  illegal <= 1'b0;
                  state   <= FETCH;
               end
            end
            FETCH: state <= DECODE;
            DECODE: begin
               ir    <= i_pm_data;
               dm_wr <= (fetch_op == OP_STO);
               dm_rd <= (fetch_op == OP_LD) || (fetch_op == OP_ADD) ||
                        (fetch_op == OP_SUB);
               state <= EXEC;
            end
            EXEC: begin
               case (op)
                  OP_HLT: state <= HALT;
                  OP_LD, OP_ADD, OP_SUB: state <= MEM;
                  OP_LDI, OP_ADDI, OP_SUBI, OP_STO: begin
                     if (op == OP_LDI)  acc <= imm;
                     if (op == OP_ADDI) acc <= acc + imm;
                     if (op == OP_SUBI) acc <= acc - imm;
                     pc    <= pc_inc;
                     state <= next_st;
                  end
                  default: begin
                     illegal <= 1'b1;
                     pc      <= pc_inc;
                     state   <= next_st;
                  end
               endcase
            end
            MEM: begin
               case (op)
                  OP_LD:   acc <= i_dm_rdata;
                  OP_ADD:  acc <= acc + i_dm_rdata;
                  default: acc <= acc - i_dm_rdata;
               endcase
               pc    <= pc_inc;
               state <= next_st;
            end
            PAUSE: if (i_step) state <= FETCH;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_bip_core_ctrl.sv
// Bench for bip_core_ctrl: directed and random programs against an
// instruction-level reference model, plus a PM_DEPTH=4 wrap instance.
`default_nettype none

module tb_bip_core_ctrl;

   logic        clk = 1'b0;
   logic        rst, start, step_mode, step;
   logic [10:0] pm_addr, dm_addr;
   logic [15:0] pm_q, dm_q, dm_wdata, acc;
   logic        dm_rd, dm_wr, busy, halted, illegal;
   logic [31:0] cycles;

   logic        w_start, w_step, w_step_mode;
   logic [10:0] w_pm_addr, w_dm_addr;
   logic [15:0] w_pm_q, w_dm_wdata, w_acc;
   logic        w_dm_rd, w_dm_wr, w_busy, w_halted, w_illegal;
   logic [31:0] w_cycles;

   logic [15:0] pm [0:2047];
   logic [15:0] dm [0:2047];
   logic [15:0] m_dm [0:2047];
   logic [15:0] pm_w [0:3];
   logic [15:0] prog_q[$];
   logic [15:0] m_trace[$];

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   bip_core_ctrl u_dut (
      .i_clock(clk), .i_reset(rst), .i_start(start), .i_step_mode(step_mode),
      .i_step(step), .o_pm_addr(pm_addr), .i_pm_data(pm_q),
      .o_dm_addr(dm_addr), .o_dm_rd(dm_rd), .o_dm_wr(dm_wr),
      .o_dm_wdata(dm_wdata), .i_dm_rdata(dm_q), .o_acc(acc), .o_busy(busy),
      .o_halted(halted), .o_illegal(illegal), .o_cycles(cycles)
   );

   bip_core_ctrl #(.PM_DEPTH(4)) u_wrap (
      .i_clock(clk), .i_reset(rst), .i_start(w_start),
      .i_step_mode(w_step_mode), .i_step(w_step), .o_pm_addr(w_pm_addr),
      .i_pm_data(w_pm_q), .o_dm_addr(w_dm_addr), .o_dm_rd(w_dm_rd),
      .o_dm_wr(w_dm_wr), .o_dm_wdata(w_dm_wdata), .i_dm_rdata(16'h0000),
      .o_acc(w_acc), .o_busy(w_busy), .o_halted(w_halted),
      .o_illegal(w_illegal), .o_cycles(w_cycles)
   );

   // Synchronous memories with one-cycle read latency.
   always @(posedge clk) begin
      pm_q   <= pm[pm_addr];
      w_pm_q <= pm_w[w_pm_addr[1:0]];
      if (dm_wr) dm[dm_addr] = dm_wdata;
      if (dm_rd) dm_q <= dm[dm_addr];
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic load_prog();
      for (int i = 0; i < 2048; i++) pm[i] = 16'h0000;
      for (int i = 0; i < prog_q.size(); i++) pm[i] = prog_q[i];
   endtask

   task automatic clear_dm();
      for (int i = 0; i < 2048; i++) dm[i] = 16'h0000;
   endtask

   // Instruction-level model: executes the program word by word.
   task automatic model_run(output logic [15:0] macc, output int mcyc, output bit mill);
      int pc;
      logic [15:0] w, sx;
      logic [4:0]  op;
      logic [10:0] opd;
      macc = 16'h0; mcyc = 0; mill = 1'b0; pc = 0;
      m_trace.delete();
      for (int i = 0; i < 2048; i++) m_dm[i] = dm[i];
      for (int n = 0; n < 500; n++) begin
         w = pm[pc]; op = w[15:11]; opd = w[10:0];
         sx = {{5{opd[10]}}, opd};
         mcyc += (op == 5'd2 || op == 5'd4 || op == 5'd6) ? 4 : 3;
         if (op == 5'd0) break;
         case (op)
            5'd1: m_dm[opd] = macc;
            5'd2: macc = m_dm[opd];
            5'd3: macc = sx;
            5'd4: macc = macc + m_dm[opd];
            5'd5: macc = macc + sx;
            5'd6: macc = macc - m_dm[opd];
            5'd7: macc = macc - sx;
            default: mill = 1'b1;
         endcase
         m_trace.push_back(macc);
         pc = (pc + 1) % 2048;
      end
   endtask

   task automatic run_main(input bit stepm);
      logic [15:0] macc;
      int mcyc, k, cnt;
      bit mill;
      model_run(macc, mcyc, mill);
      step_mode = stepm;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      chk("illegal_clr", illegal, 0);
      k = 0; cnt = 0;
      while (!halted && cnt < 4000) begin
         if (!busy) begin
            chk("step_acc", acc, (k < m_trace.size()) ? m_trace[k] : 16'hDEAD);
            k++;
            step = 1'b1;
            @(negedge clk) step = 1'b0;
         end else begin
            @(negedge clk);
         end
         cnt++;
      end
      if (cnt >= 4000) chk("halt_timeout", 0, 1);
      chk("pauses", k, stepm ? m_trace.size() : 0);
      chk("acc", acc, macc);
      chk("cycles", cycles, mcyc);
      chk("illegal", illegal, mill);
      chk("halted", halted, 1);
      for (int i = 0; i < 16; i++) chk("dm", dm[i], m_dm[i]);
      step_mode = 1'b0;
   endtask

   task automatic reset_mid(input bit in_mem);
      int cnt;
      prog_q = {16'h1805, 16'h2003, 16'h0000};
      load_prog();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      cnt = 0;
      while (!dm_rd && cnt < 50) begin @(negedge clk); cnt++; end
      chk("rd_seen", dm_rd, 1);
      if (in_mem) begin @(posedge clk); #2; end
      chk("acc_pre_rst", acc, 16'h0005);
      rst = 1'b1;
      #1;
      chk("rst_acc", acc, 0);
      chk("rst_rd", dm_rd, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cycles", cycles, 0);
      chk("rst_pc", pm_addr, 0);
      @(negedge clk) rst = 1'b0;
   endtask

   initial begin
      logic [15:0] wacc;
      int cnt;
      rst = 1'b1; start = 1'b0; step_mode = 1'b0; step = 1'b0;
      w_start = 1'b0; w_step = 1'b0; w_step_mode = 1'b1;
      clear_dm();
      prog_q = {};
      load_prog();
      pm_w[0] = 16'h1801; pm_w[1] = 16'h2801; pm_w[2] = 16'h2801; pm_w[3] = 16'h2801;
      #12;
      chk("rst_acc0", acc, 0);
      chk("rst_busy0", busy, 0);
      chk("rst_halted0", halted, 0);
      chk("rst_illegal0", illegal, 0);
      chk("rst_cycles0", cycles, 0);
      chk("rst_strobes0", {dm_rd, dm_wr}, 0);
      chk("rst_pc0", pm_addr, 0);
      @(negedge clk) rst = 1'b0;

      // Reference program, free-running then single-stepped.
      prog_q = {16'h1805, 16'h2FFE, 16'h0803, 16'h2003, 16'h0000};
      load_prog();
      run_main(1'b0);
      chk("ex_acc", acc, 16'h0006);
      chk("ex_dm3", dm[3], 16'h0003);
      chk("ex_cycles", cycles, 16);
      clear_dm();
      run_main(1'b1);
      chk("ex_step_acc", acc, 16'h0006);

      // Wraparound of add/sub.
      clear_dm();
      dm[0] = 16'h7FFF;
      prog_q = {16'h1000, 16'h2801, 16'h0000};
      load_prog();
      run_main(1'b0);
      chk("ovf_acc", acc, 16'h8000);
      prog_q = {16'h1800, 16'h3801, 16'h0000};
      load_prog();
      run_main(1'b0);
      chk("unf_acc", acc, 16'hFFFF);

      // Illegal opcode, then a clean program clears the flag.
      prog_q = {16'h1805, 16'hF800, 16'h0000};
      load_prog();
      run_main(1'b0);
      chk("ill_flag", illegal, 1);
      chk("ill_acc", acc, 16'h0005);
      prog_q = {16'h1801, 16'h0000};
      load_prog();
      run_main(1'b0);
      chk("ill_cleared", illegal, 0);

      // Random straight-line programs.
      for (int t = 0; t < 10; t++) begin
         clear_dm();
         for (int i = 0; i < 16; i++) dm[i] = 16'($urandom);
         prog_q.delete();
         for (int i = 0; i < int'($urandom_range(1, 20)); i++) begin
            int sel;
            logic [4:0]  op;
            logic [10:0] opd;
            sel = int'($urandom_range(1, 8));
            op  = (sel == 8) ? 5'($urandom_range(8, 31)) : 5'(sel);
            opd = (op == 5'd1 || op == 5'd2 || op == 5'd4 || op == 5'd6)
                  ? 11'($urandom_range(0, 15)) : 11'($urandom);
            prog_q.push_back({op, opd});
         end
         prog_q.push_back(16'h0000);
         load_prog();
         run_main(t[0]);
      end

      // Asynchronous reset in EXEC and in MEM of an ADD.
      reset_mid(1'b0);
      reset_mid(1'b1);

      // PM_DEPTH=4 instance: PC wraps 3 -> 0, LDI re-executes.
      @(negedge clk) w_start = 1'b1;
      @(negedge clk) w_start = 1'b0;
      wacc = 16'h0;
      for (int k = 0; k < 5; k++) begin
         cnt = 0;
         while (w_busy && cnt < 100) begin @(negedge clk); cnt++; end
         if (cnt >= 100) chk("wrap_timeout", 0, 1);
         wacc = (k % 4 == 0) ? 16'h0001 : wacc + 16'h0001;
         chk("wrap_acc", w_acc, wacc);
         chk("wrap_pc", w_pm_addr, (k + 1) % 4);
         w_step = 1'b1;
         @(negedge clk) w_step = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

`default_nettype wire
